avalon_st_arbiter: RTL
======================

# avalon_st_arbiter

Round-robin arbiter that shares one Avalon-ST sink between `NUM_SRC` Avalon-ST sources, such as several byte-stream generators. It grants one source at a time for a burst of at most `BURST_MAX` beats, then rotates priority. All beats pass through a single registered output stage to the shared sink.

## Interface
Parameters:
- `NUM_SRC`, 2: number of requesting sources, legal range 2..4.
- `DATA_W`, 8: beat width in bits.
- `BURST_MAX`, 3: maximum beats accepted per grant, legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `src_valid`  in  `NUM_SRC`  per-source valid; bit i belongs to source i.
- `src_data`  in  `NUM_SRC*DATA_W`  per-source data; source i occupies bits `[i*DATA_W +: DATA_W]`.
- `src_ready`  out  `NUM_SRC`  per-source ready (combinational).
- `out_valid`  out  1  registered valid to the sink.
- `out_data`  out  `DATA_W`  registered data to the sink.
- `out_ready`  in  1  sink ready.
- `grant`  out  2  index of the owning source; meaningful only while `busy`=1.
- `busy`  out  1  1 while in state GRANT.

## Operation
- Handshake protocol: Avalon-ST with ready latency 0 on both sides. A beat transfers in any cycle where valid=1 and ready=1.
- Output register:
  - `can_load = !out_valid || out_ready`.
  - If a source beat is accepted, load it into `out_data` and set `out_valid`=1.
  - Otherwise, if `out_valid && out_ready`, clear `out_valid`.
  - `out_data` holds its value when not loaded.
- Ready generation: `src_ready[i] = busy && (grant==i) && can_load`. All other ready bits are 0.
- State IDLE:
  - If any `src_valid` is 1, select the first asserted index searching `last+1, last+2, …` modulo `NUM_SRC`, ending at `last`.
  - On selection: register it in `grant`, clear `beat_cnt`, go to GRANT.
  - If no `src_valid` is 1, stay in IDLE.
- State GRANT, evaluated only in cycles where `src_ready[grant]`=1:
  - `src_valid[grant]`=1 and `beat_cnt == BURST_MAX-1`: accept the beat, set `last=grant`, go to IDLE.
  - `src_valid[grant]`=1 otherwise: accept the beat, increment `beat_cnt`, stay in GRANT.
  - `src_valid[grant]`=0: accept nothing, set `last=grant`, go to IDLE.
- Stalled GRANT cycles (`can_load`=0): hold state, `beat_cnt` and `grant`, whatever `src_valid` does.
- Width of `beat_cnt`: 4 bits.
- Sources must not drop valid or change data while valid is high and ready is low. The block does not check this.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `src_ready`=0, `grant`=0, `busy`=0.
  - State IDLE, `beat_cnt`=0, `last=NUM_SRC-1`, so source 0 has first priority.
- Reset mid-operation: any beat held in the output register is discarded; there is no partial-burst recovery.
- Arbitration latency:
  - A request seen in IDLE in cycle T gives `busy`=1 in T+1.
  - The earliest accept is in T+1, and its `out_valid` is in T+2.
- Throughput: 1 beat/cycle within a burst while `out_ready`=1.
- Re-arbitration bubble: exactly 1 cycle in IDLE between bursts, with all `src_ready`=0.
- Release on valid-drop: a granted source whose valid is low in an unstalled cycle loses the grant. A late beat from it waits for its next turn.
- Simultaneous requests: the round-robin order decides. The source just served has lowest priority in the next arbitration.
- Single requester: it is re-granted after each 1-cycle IDLE bubble, giving `BURST_MAX` beats per `BURST_MAX+1` cycles.
- `out_ready`=0 with `out_valid`=1: `out_valid` and `out_data` stay stable.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle with `src_valid`=2'b11 → `out_valid`, `busy` and `src_ready` drop to 0 immediately; after release, source 0 is granted first.
- Single source, `NUM_SRC`=2, `BURST_MAX`=3, `out_ready`=1: source 0 holds data 4,5,6,7 continuously → `out_data` shows 4,5,6, one bubble, then 7. `grant`=0 throughout.
- Fairness: both sources always valid (source 0 streams 0x10.., source 1 streams 0x20..) → output 10,11,12,20,21,22,13,14,15,… with one bubble between bursts.
- Backpressure: hold `out_ready`=0 for 4 cycles mid-burst → `out_data` is stable, `src_ready[grant]`=0, `beat_cnt` is frozen; the burst completes after release with no beat lost or duplicated.
- Valid drop: source 1 is granted and sends one beat 0xA1, then deasserts valid while source 0 requests → grant moves to source 0 after one IDLE cycle; source 1's later 0xA2 is delivered on its next grant.
- `BURST_MAX`=1, `NUM_SRC`=4, all sources valid → grants follow 0,1,2,3,0 with one beat each, one bubble apart.

Source files
------------

// File: rtl/avalon_st_arbiter.sv
// Round-robin arbiter sharing one Avalon-ST sink between NUM_SRC sources.
// Grants one source for up to BURST_MAX beats, then rotates; registered output stage.
module avalon_st_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [1:0]                grant,
  output logic                      busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                          state_q;
  logic [1:0]                      grant_q;
  logic [1:0]                      last_q;
  logic [3:0]                      beat_cnt_q;
  logic                            out_valid_q;
  logic [DATA_W-1:0]               out_data_q;

  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data_a;
  logic                            can_load;
  logic                            sel_valid;
  logic [DATA_W-1:0]               sel_data;
  logic                            accept;
  logic                            nxt_found;
  logic [1:0]                      nxt_idx;

  assign src_data_a = src_data;
  assign busy       = (state_q == GRANT);
  assign can_load   = !out_valid_q || out_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_rdy
    assign src_ready[g] = busy && (grant_q == 2'(g)) && can_load;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 2'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data_a[i];
      end
    end
  end

  assign accept = busy && can_load && sel_valid;

  // Search last+1, last+2, ... wrapping; the source just served is considered last.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = last_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!nxt_found && src_valid[i] && ((int'(last_q) + k) % NUM_SRC) == i) begin
          nxt_found = 1'b1;
          nxt_idx   = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= 2'(NUM_SRC - 1);
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        out_data_q  <= sel_data;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (nxt_found) begin
            grant_q    <= nxt_idx;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          // Stalled cycles leave grant and beat count untouched.
          if (can_load) begin
            if (sel_valid && beat_cnt_q != 4'(BURST_MAX - 1)) begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end else begin
              last_q  <= grant_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant     = grant_q;

endmodule
